// File: rtl/uart_pkg.sv
// Shared definitions for the 9600-baud 8N1 UART pair.
// The transmitter derives its 625-count half-period from DEFAULT_CLKS_PER_BIT.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 1250;
  localparam int DATA_BITS            = 8;
  localparam int IDX_W                = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is a parameter so an idle-high line does not look like an edge after reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge; blocking here would collapse them into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, one-entry output buffer with valid/ack,
// single-cycle framing-error pulse and sticky overrun flag.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic                 hwclk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int                 TIMER_W   = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF_BIT - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DATA_BITS - 1);

  rx_state_e              state, state_next;
  logic [TIMER_W-1:0]     timer, timer_next;
  logic [IDX_W-1:0]       idx, idx_next;
  logic [DATA_BITS-1:0]   shreg, shreg_next;
  logic                   rx_s;
  logic                   accept;
  logic                   ferr_set;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (hwclk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      timer <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      idx   <= idx_next;
      shreg <= shreg_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    timer_next = timer;
    idx_next   = idx;
    shreg_next = shreg;
    accept     = 1'b0;
    ferr_set   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_next = ST_START;
          timer_next = '0;
        end
      end

      ST_START: begin
        if (timer == HALF_LAST) begin
          timer_next = '0;
          idx_next   = '0;
          // A line back high at mid start bit was a glitch, not a frame.
          state_next = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end

      ST_DATA: begin
        if (timer == BIT_LAST) begin
          shreg_next = {rx_s, shreg[DATA_BITS-1:1]};
          idx_next   = idx + IDX_W'(1);
          timer_next = '0;
          if (idx == IDX_LAST) begin
            state_next = ST_STOP;
          end
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end

      ST_STOP: begin
        if (timer == BIT_LAST) begin
          timer_next = '0;
          if (rx_s) begin
            accept     = 1'b1;
            state_next = ST_IDLE;
          end else begin
            ferr_set   = 1'b1;
            state_next = ST_BREAK;
          end
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end

      ST_BREAK: begin
        // Holding here until the line recovers turns a long break into a single error.
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      if (accept) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
        // Newest byte wins; an ack landing in the same cycle consumed the old one.
        if (rx_valid && !rx_ack) begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule : uart_rx_8n1

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: a fast instance (16 clocks/bit) for the directed
// cases and a default-rate instance driven with +/-2% baud skew.
module tb_uart_rx_8n1;

  localparam int CPB   = 16;
  localparam int CPB_B = 1250;
  localparam int LAT_A = 2 + 1 + CPB / 2 + 9 * CPB;

  logic       hwclk = 1'b0;
  logic       rst_n;
  logic       rx, rx_b;
  logic       rx_ack, rx_ack_b;
  logic [7:0] rx_data, rx_data_b;
  logic       rx_valid, rx_valid_b;
  logic       frame_err, frame_err_b;
  logic       overrun, overrun_b;
  logic       busy, busy_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ferr_a  = 0;
  int ferr_b  = 0;
  int busy_a  = 0;
  int t_start = 0;
  int t_valid = 0;
  int f0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic       pv_a = 1'b0, pv_b = 1'b0;
  logic [7:0] pd_a = '0, pd_b = '0;
  logic [7:0] e_a, e_b;

  always #5 hwclk = ~hwclk;
  always @(posedge hwclk) cyc <= cyc + 1;

  uart_rx_8n1 #(
    .CLKS_PER_BIT (CPB)
  ) dut_a (
    .hwclk     (hwclk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  uart_rx_8n1 dut_b (
    .hwclk     (hwclk),
    .rst_n     (rst_n),
    .rx        (rx_b),
    .rx_data   (rx_data_b),
    .rx_valid  (rx_valid_b),
    .rx_ack    (rx_ack_b),
    .frame_err (frame_err_b),
    .overrun   (overrun_b),
    .busy      (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitors: a new byte is a rising rx_valid or a changed rx_data while valid.
  always @(negedge hwclk) begin
    if (frame_err) ferr_a++;
    if (busy) busy_a++;
    if (rx_valid && (!pv_a || rx_data != pd_a)) begin
      if (!pv_a) t_valid = cyc;
      if (q_a.size() != 0) e_a = q_a.pop_front();
      else e_a = ~rx_data;
      check("byte_a", 32'(rx_data), 32'(e_a));
    end
    pv_a = rx_valid;
    pd_a = rx_data;
  end

  always @(negedge hwclk) begin
    if (frame_err_b) ferr_b++;
    if (rx_valid_b && (!pv_b || rx_data_b != pd_b)) begin
      if (q_b.size() != 0) e_b = q_b.pop_front();
      else e_b = ~rx_data_b;
      check("byte_b", 32'(rx_data_b), 32'(e_b));
    end
    pv_b = rx_valid_b;
    pd_b = rx_data_b;
  end

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rx_b = v;
    else rx = v;
    repeat (n) @(negedge hwclk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop, input int cpb);
    if (stop) begin
      if (sel) q_b.push_back(b);
      else q_a.push_back(b);
    end
    if (!sel) t_start = cyc;
    drive(sel, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(sel, b[i], cpb);
    drive(sel, stop, cpb);
  endtask

  task automatic pulse_ack(input bit sel);
    if (sel) rx_ack_b = 1'b1;
    else rx_ack = 1'b1;
    @(negedge hwclk);
    rx_ack   = 1'b0;
    rx_ack_b = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    rx       = 1'b1;
    rx_b     = 1'b1;
    rx_ack   = 1'b0;
    rx_ack_b = 1'b0;
    repeat (3) @(negedge hwclk);
    check("rst_data", 32'(rx_data), 32'h0);
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    drive(0, 1'b1, 20);

    // Single byte, no ack, then ack clears valid on the next cycle.
    f0 = ferr_a;
    send_frame(0, 8'hA5, 1'b1, CPB);
    drive(0, 1'b1, 8);
    check("a5_valid", 32'(rx_valid), 32'h1);
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_ferr", 32'(ferr_a - f0), 32'h0);
    check("a5_overrun", 32'(overrun), 32'h0);
    check("a5_latency", 32'(t_valid - t_start), 32'(LAT_A));
    pulse_ack(0);
    check("a5_ack_valid", 32'(rx_valid), 32'h0);

    // Two bytes without ack: newest wins and overrun sticks until ack.
    send_frame(0, 8'h3C, 1'b1, CPB);
    drive(0, 1'b1, 4);
    send_frame(0, 8'hC3, 1'b1, CPB);
    drive(0, 1'b1, 8);
    check("ovr_data", 32'(rx_data), 32'hC3);
    check("ovr_flag", 32'(overrun), 32'h1);
    pulse_ack(0);
    check("ovr_ack_valid", 32'(rx_valid), 32'h0);
    check("ovr_ack_flag", 32'(overrun), 32'h0);

    // Bad stop bit followed by a long break: one error, no byte, then recovery.
    f0 = ferr_a;
    send_frame(0, 8'h55, 1'b0, CPB);
    drive(0, 1'b0, 40 * CPB);
    drive(0, 1'b1, 3 * CPB);
    check("brk_ferr_count", 32'(ferr_a - f0), 32'h1);
    check("brk_valid", 32'(rx_valid), 32'h0);
    send_frame(0, 8'h81, 1'b1, CPB);
    drive(0, 1'b1, 2 * CPB);
    check("brk_next_data", 32'(rx_data), 32'h81);
    check("brk_next_overrun", 32'(overrun), 32'h0);
    pulse_ack(0);

    // Short glitch on an idle line: start bit rejected at its midpoint.
    f0     = ferr_a;
    busy_a = 0;
    drive(0, 1'b0, 5);
    drive(0, 1'b1, 40);
    check("glitch_busy_cycles", 32'(busy_a), 32'(CPB / 2));
    check("glitch_valid", 32'(rx_valid), 32'h0);
    check("glitch_ferr", 32'(ferr_a - f0), 32'h0);

    // Reset in the middle of bit 4 of 0xFF, then a clean 0x12.
    drive(0, 1'b0, CPB);
    drive(0, 1'b1, 4 * CPB + CPB / 2);
    check("mid_busy_before_rst", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(negedge hwclk);
    check("mid_rst_data", 32'(rx_data), 32'h0);
    check("mid_rst_valid", 32'(rx_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_overrun", 32'(overrun), 32'h0);
    check("mid_rst_ferr", 32'(frame_err), 32'h0);
    repeat (3) @(negedge hwclk);
    rst_n = 1'b1;
    f0    = ferr_a;
    drive(0, 1'b1, 2 * CPB);
    send_frame(0, 8'h12, 1'b1, CPB);
    drive(0, 1'b1, 2 * CPB);
    check("post_rst_data", 32'(rx_data), 32'h12);
    check("post_rst_valid", 32'(rx_valid), 32'h1);
    check("post_rst_ferr", 32'(ferr_a - f0), 32'h0);
    check("post_rst_pending_a", 32'(q_a.size()), 32'h0);

    // Default rate with the transmitter running 2% slow, 2% fast, 2% slow.
    drive(1, 1'b1, 200);
    send_frame(1, 8'h00, 1'b1, CPB_B + CPB_B / 50);
    drive(1, 1'b1, 100);
    check("skew_00_data", 32'(rx_data_b), 32'h00);
    pulse_ack(1);
    send_frame(1, 8'hFF, 1'b1, CPB_B - CPB_B / 50);
    drive(1, 1'b1, 100);
    check("skew_ff_data", 32'(rx_data_b), 32'hFF);
    pulse_ack(1);
    send_frame(1, 8'h6E, 1'b1, CPB_B + CPB_B / 50);
    drive(1, 1'b1, 100);
    check("skew_6e_data", 32'(rx_data_b), 32'h6E);
    check("skew_valid", 32'(rx_valid_b), 32'h1);
    check("skew_ferr", 32'(ferr_b), 32'h0);
    check("skew_overrun", 32'(overrun_b), 32'h0);
    check("skew_pending_b", 32'(q_b.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_8n1

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- Receive-side counterpart of the 9600-baud 8N1 UART transmitter.
- Samples the serial rx line on hwclk using a mid-bit timer and deserialises 8N1 frames, LSB first.
- Holds each received byte in a one-entry buffer with a valid/ack handshake toward the lock controller logic.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 1250, hwclk cycles per bit (12 MHz / 9600); minimum 4.
- HALF_BIT, CLKS_PER_BIT/2, cycles from the start-edge detect to the start-bit mid-sample.

Ports:
- hwclk  input  1  system clock, 12 MHz.
- rst_n  input  1  reset, asynchronous, active-low.
- rx  input  1  serial line, asynchronous to hwclk, idle high.
- rx_data  output  8  last accepted byte.
- rx_valid  output  1  rx_data holds an unacknowledged byte.
- rx_ack  input  1  consumer has taken rx_data; sampled only while rx_valid=1.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: a byte was overwritten before ack.
- busy  output  1  frame reception in progress (state != IDLE).

Behaviour:
- Clock and reset: single clock, hwclk. Reset is asynchronous and active-low (rst_n).
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, both synchroniser flops=1, state=IDLE, timer=0, bit index=0.
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s, adding 2 cycles of latency.
- IDLE: rx_s==0 -> START, timer=0.
- START: timer counts up. At timer==HALF_BIT-1, sample rx_s:
  - 0 -> DATA, timer=0, idx=0.
  - 1 -> false start (glitch), back to IDLE with no outputs touched.
- DATA: at timer==CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register (shift right), idx++, timer=0. After the 8th sample (idx wraps 7->0) -> STOP.
- STOP: at timer==CLKS_PER_BIT-1, sample rx_s:
  - 1 -> byte accepted, -> IDLE.
  - 0 -> frame_err=1 for exactly one cycle, byte discarded, -> BREAK.
- BREAK: wait for rx_s==1, then -> IDLE. A held-low line (break) produces exactly one frame_err, not repeated errors.
- Byte accept cycle (registered outputs, visible next cycle):
  - rx_data<=shift register, rx_valid<=1.
  - If rx_valid was already 1 and rx_ack=0 in the same cycle: overrun<=1 and rx_data is overwritten (newest byte wins).
  - If rx_ack=1 in the same cycle as accept: rx_valid stays 1, new data is loaded, overrun is not set.
- Handshake: rx_valid=1 and rx_ack=1 with no accept -> rx_valid<=0 and overrun<=0. rx_ack while rx_valid=0 is ignored.
- Latency: rx_valid rises 2 (sync) + 1 cycles after the mid-stop-bit sample.
- Timer: width $clog2(CLKS_PER_BIT). It never wraps because it is reset on every sample.
- Reception is independent of the handshake: a new frame is received while rx_valid=1.
- Reset asserted mid-frame returns everything to reset values immediately. After reset, a line still low is treated as a start edge once rx_s==0 is seen in IDLE.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, BREAK)
  - DEFAULT_CLKS_PER_BIT=1250 (shared with the transmitter's 625-count half-period derivation)
  - DATA_BITS=8
- One sub-module: sync_2ff (2-flop synchroniser, reset value parameterised, here 1).

Test Plan (CLKS_PER_BIT=16 unless noted):
- Send 0xA5 at 16 cycles/bit, rx_ack held 0 -> rx_valid=1, rx_data=0xA5, frame_err=0, overrun=0. Pulse rx_ack -> rx_valid=0 next cycle.
- Send 0x3C then 0xC3 with no ack -> rx_data=0xC3, overrun=1. Ack -> rx_valid=0, overrun=0.
- Send 0x55 with stop bit forced 0, line held low for 40 bit-times, then released -> exactly one frame_err pulse, rx_valid stays 0. Following 0x81 is received correctly.
- 5-cycle low glitch on idle rx -> state returns to IDLE, no rx_valid, no frame_err; busy high for ~8 cycles only.
- Assert rst_n=0 during bit 4 of 0xFF, release, then send 0x12 -> all outputs 0 during reset, then rx_data=0x12, no spurious byte.
- Default CLKS_PER_BIT=1250 driven by a transmitter-model at 9600 baud with ±2% rate skew, sending 0x00, 0xFF, 0x6E -> all three received correctly, no errors.
